// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM between a DDS read window (priority) and a host load/readback port
module sram_arbiter #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dds_go,
  input  logic [AW-1:0]    dds_addr,
  output logic [DW-1:0]    dds_data,
  input  logic             host_req,
  input  logic             host_we,
  input  logic [AW-1:0]    host_addr,
  input  logic [DW-1:0]    host_wdata,
  output logic             host_ack,
  output logic [DW-1:0]    host_rdata,
  output logic [CNT_W-1:0] preempt_cnt,
  output logic [AW-1:0]    sram_addr,
  output logic [DW-1:0]    sram_dq_o,
  output logic             sram_dq_oe,
  input  logic [DW-1:0]    sram_dq_i,
  output logic             sram_ce_n,
  output logic             sram_oe_n,
  output logic             sram_we_n
);
  typedef enum logic [2:0] {IDLE, R1, R2, W1, W2, W3, PEND} state_t;
  state_t           state_q, state_d;
  logic             go_q;
  logic [1:0]       win_q, win_d;
  logic             ack_q, ack_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic             we_q, we_d;
  logic [AW-1:0]    haddr_q, haddr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [AW-1:0]    saddr_q;
  logic             go_edge, win_on, free, abort;
  assign go_edge     = dds_go & ~go_q;
  assign win_on      = win_q != 2'd0;
  assign win_d       = go_edge ? 2'd2 : (win_on ? win_q - 2'd1 : 2'd0);
  // the host may only start a cycle that the window will not occupy
  assign free        = win_d == 2'd0;
  assign dds_data    = sram_dq_i;
  assign host_ack    = ack_q;
  assign host_rdata  = rdata_q;
  assign preempt_cnt = pre_q;
  // host FSM: accept, run the access, abort to PEND on a go edge and replay
  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    abort   = 1'b0;
    we_d    = we_q;
    haddr_d = haddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (host_req && free) begin
        we_d    = host_we;
        haddr_d = host_addr;
        wdata_d = host_wdata;
        state_d = host_we ? W1 : R1;
      end
      R1: begin
        abort   = go_edge;
        state_d = go_edge ? PEND : R2;
      end
      R2: begin
        rdata_d = sram_dq_i;
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      W1: begin
        abort   = go_edge;
        state_d = go_edge ? PEND : W2;
      end
      W2: begin
        abort   = go_edge;
        state_d = go_edge ? PEND : W3;
      end
      W3: begin
        ack_d   = 1'b1;
        state_d = IDLE;
      end
      PEND: state_d = free ? (we_q ? W1 : R1) : PEND;
      default: state_d = IDLE;
    endcase
    pre_d = (abort && !(&pre_q)) ? pre_q + 1'b1 : pre_q;
  end
  // SRAM pin decode: window wins, then the host access, else idle with address held
  always_comb begin
    sram_addr  = saddr_q;
    sram_dq_o  = wdata_q;
    sram_dq_oe = 1'b0;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    if (win_on) begin
      sram_addr = dds_addr;
      sram_ce_n = 1'b0;
      sram_oe_n = 1'b0;
    end else if (state_q == R1 || state_q == R2) begin
      sram_addr = haddr_q;
      sram_ce_n = 1'b0;
      sram_oe_n = 1'b0;
    end else if (state_q == W1 || state_q == W2 || state_q == W3) begin
      sram_addr  = haddr_q;
      sram_dq_oe = 1'b1;
      sram_ce_n  = 1'b0;
      sram_we_n  = state_q != W2;
    end
  end
  // state and held registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      win_q   <= 2'd0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      pre_q   <= '0;
      we_q    <= 1'b0;
      haddr_q <= '0;
      wdata_q <= '0;
      saddr_q <= '0;
    end else begin
      state_q <= state_d;
      go_q    <= dds_go;
      win_q   <= win_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      pre_q   <= pre_d;
      we_q    <= we_d;
      haddr_q <= haddr_d;
      wdata_q <= wdata_d;
      saddr_q <= sram_addr;
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of window priority, host timing, abort/replay and reset
module tb_sram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        dds_go;
  logic [15:0] dds_addr;
  logic [15:0] dds_data;
  logic        host_req, host_we;
  logic [15:0] host_addr, host_wdata, host_rdata;
  logic        host_ack;
  logic [7:0]  preempt_cnt;
  logic [15:0] sram_addr, sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [15:0] mem [0:255];
  int n_chk = 0, n_pass = 0;
  int wep = 0, ackn = 0;
  int lat, w0, a0, cnt;

  sram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .dds_go(dds_go), .dds_addr(dds_addr), .dds_data(dds_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .preempt_cnt(preempt_cnt),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  // SRAM model: synchronous write, asynchronous read
  always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_addr[7:0]] <= sram_dq_o;
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0;

  always @(negedge clk) begin
    if (!sram_we_n) wep++;
    if (host_ack) ackn++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_access(input logic we, input logic [15:0] a, input logic [15:0] d, output int l);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    l = -1;
    for (int i = 1; i <= 20 && l < 0; i++) begin
      step();
      if (host_ack) l = i;
    end
    host_req = 1'b0;
    if (l < 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; dds_go = 1'b0; dds_addr = 16'h0005;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    step(); step();
    rst_n = 1'b1;
    check("rst_ce_n", sram_ce_n, 1);
    check("rst_we_n", sram_we_n, 1);
    check("rst_addr", sram_addr, 0);
    check("rst_ack", host_ack, 0);
    check("rst_pre", preempt_cnt, 0);
    step();
    // basic write then read
    w0 = wep;
    host_access(1'b1, 16'h0042, 16'h1234, lat);
    check("wr_lat", lat, 4);
    check("wr_pulse", wep - w0, 1);
    check("wr_mem", mem[8'h42], 16'h1234);
    host_access(1'b0, 16'h0042, 16'h0, lat);
    check("rd_lat", lat, 3);
    check("rd_data", host_rdata, 16'h1234);
    host_access(1'b1, 16'h0005, 16'h5A5A, lat);
    step();
    // go edge at the end of W2: abort, window, full replay
    w0 = wep; a0 = ackn;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 16'hBEEF;
    step();
    check("w1_we_n", sram_we_n, 1);
    check("w1_dq_oe", sram_dq_oe, 1);
    step();
    check("w2_we_n", sram_we_n, 0);
    dds_go = 1'b1;
    step();
    check("win1_addr", sram_addr, 16'h0005);
    check("win1_oe_n", sram_oe_n, 0);
    check("win1_dq_oe", sram_dq_oe, 0);
    check("win1_data", dds_data, 16'h5A5A);
    check("abort_pre", preempt_cnt, 1);
    check("abort_noack", host_ack, 0);
    step();
    check("win2_oe_n", sram_oe_n, 0);
    check("win2_addr", sram_addr, 16'h0005);
    step();
    check("replay_w1", sram_addr, 16'h0010);
    check("replay_oe", sram_dq_oe, 1);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      step();
      if (host_ack) lat = i;
    end
    host_req = 1'b0; dds_go = 1'b0;
    check("replay_lat", lat, 3);
    step(); step();
    check("replay_acks", ackn - a0, 1);
    check("replay_pulses", wep - w0, 2);
    host_access(1'b0, 16'h0010, 16'h0, lat);
    check("replay_rd", host_rdata, 16'hBEEF);
    step();
    // host request and go edge on the same posedge
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0042; dds_go = 1'b1;
    step();
    check("same_win_addr", sram_addr, 16'h0005);
    check("same_win_oe", sram_oe_n, 0);
    step();
    check("same_win2_addr", sram_addr, 16'h0005);
    step();
    check("same_host_addr", sram_addr, 16'h0042);
    check("same_host_oe", sram_oe_n, 0);
    step(); step();
    check("same_ack", host_ack, 1);
    check("same_rdata", host_rdata, 16'h1234);
    host_req = 1'b0; dds_go = 1'b0;
    check("same_pre", preempt_cnt, 1);
    step(); step();
    // level-high go yields one window
    dds_go = 1'b1; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!sram_oe_n) cnt++;
    end
    dds_go = 1'b0;
    check("level_win", cnt, 2);
    step();
    // go edge at the end of W3: ack, no replay
    w0 = wep; a0 = ackn;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0020; host_wdata = 16'h7777;
    step(); step(); step();
    dds_go = 1'b1;
    step();
    host_req = 1'b0;
    check("w3_ack", host_ack, 1);
    check("w3_win", sram_addr, 16'h0005);
    for (int i = 0; i < 8; i++) step();
    dds_go = 1'b0;
    check("w3_acks", ackn - a0, 1);
    check("w3_pulses", wep - w0, 1);
    check("w3_pre", preempt_cnt, 1);
    host_access(1'b0, 16'h0020, 16'h0, lat);
    check("w3_rd", host_rdata, 16'h7777);
    step();
    // asynchronous reset in the middle of W2
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0030; host_wdata = 16'h9999;
    step(); step();
    check("rw2_we_n", sram_we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("ar_we_n", sram_we_n, 1);
    check("ar_dq_oe", sram_dq_oe, 0);
    check("ar_ce_n", sram_ce_n, 1);
    check("ar_addr", sram_addr, 0);
    check("ar_rdata", host_rdata, 0);
    check("ar_pre", preempt_cnt, 0);
    host_req = 1'b0;
    step();
    check("ar_ack", host_ack, 0);
    rst_n = 1'b1;
    step();
    // forced preempts until saturation
    for (int k = 1; k <= 300; k++) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0040; host_wdata = k[15:0];
      step();
      dds_go = 1'b1;
      step();
      dds_go = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20 && lat < 0; i++) begin
        step();
        if (host_ack) lat = i;
      end
      host_req = 1'b0;
      if (lat < 0) check("sat_timeout", 32'd0, 32'd1);
      if (k == 100) check("pre_100", preempt_cnt, 100);
      if (k == 255) check("pre_255", preempt_cnt, 255);
    end
    check("pre_sat", preempt_cnt, 255);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
